// File: rtl/seq_gen_param_pkg.sv
// Shared types and helpers for the parametrised sequence generator.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DFLT_N = 8;

  // Power-on table contents; entries past the first eight read as zero.
  function automatic logic [7:0] dflt_word(input int i);
    case (i)
      0:       return 8'hAF;
      1:       return 8'hBC;
      2:       return 8'hE2;
      3:       return 8'h78;
      4:       return 8'hFF;
      5:       return 8'hE2;
      6:       return 8'h0B;
      7:       return 8'h8D;
      default: return 8'h00;
    endcase
  endfunction

  // A zero or oversize length means "play the whole table".
  function automatic int clamp_len(input int cfg, input int depth);
    return (cfg <= 0 || cfg > depth) ? depth : cfg;
  endfunction

endpackage

// File: rtl/seq_gen_param_if.sv
// Valid/ready word stream between the generator and its consumer.
interface seq_gen_param_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] data;
  logic              data_valid;
  logic              data_ready;

  modport master (output data, output data_valid, input data_ready);
  modport slave  (input data, input data_valid, output data_ready);
endinterface

// File: rtl/seq_gen_param_table.sv
// Sequence table: register file that resets to the package defaults.
module seq_table import seq_gen_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DEPTH-1:0][DATA_W-1:0] mem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= DATA_W'(dflt_word(i));
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (we && waddr == ADDR_W'(i)) mem_q[i] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/seq_gen_param.sv
// Replays the programmable table as a valid/ready stream, one-shot or looped.
module seq_gen_param import seq_gen_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int LEN_W  = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic              enable,
  input  logic              loop_mode,
  input  logic [LEN_W-1:0]  len_cfg,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  seq_gen_param_if.master   st,
  output logic              busy,
  output logic              done,
  output logic              wrap,
  output logic              wr_err
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              loop_q, loop_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              dv_q, dv_d;
  logic              wrap_q, wrap_d;
  logic              werr_q, werr_d;

  logic              xfer, last, addr_ok, tbl_we;
  logic [ADDR_W-1:0] nxt_idx, rd_addr;
  logic [DATA_W-1:0] rd_data;

  assign xfer    = dv_q && st.data_ready;
  assign last    = LEN_W'(idx_q) == len_q - LEN_W'(1);
  assign nxt_idx = last ? '0 : idx_q + ADDR_W'(1);
  // A presented word always reads ahead to the index it will advance to.
  assign rd_addr = dv_q ? nxt_idx : idx_q;
  assign addr_ok = int'(wr_addr) < DEPTH;
  assign tbl_we  = wr_en && addr_ok && state_q == ST_IDLE;

  seq_table #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_tbl (
    .clk   (clk),
    .rst_n (reset_n),
    .we    (tbl_we),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    loop_d  = loop_q;
    data_d  = data_q;
    dv_d    = dv_q;
    wrap_d  = 1'b0;
    werr_d  = wr_en && !tbl_we;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_RUN;
        idx_d   = '0;
        loop_d  = loop_mode;
        len_d   = LEN_W'(clamp_len(int'(len_cfg), DEPTH));
        dv_d    = 1'b0;
      end
      ST_RUN: begin
        if (stop) begin
          dv_d    = 1'b0;
          state_d = ST_IDLE;
        end else if (xfer && last && !loop_q) begin
          dv_d    = 1'b0;
          state_d = ST_DONE;
        end else if (xfer || !dv_q) begin
          if (xfer) begin
            idx_d  = nxt_idx;
            wrap_d = last;
          end
          dv_d = enable;
          if (enable) data_d = rd_data;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      loop_q  <= 1'b0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      wrap_q  <= 1'b0;
      werr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      loop_q  <= loop_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      wrap_q  <= wrap_d;
      werr_q  <= werr_d;
    end
  end

  assign st.data       = data_q;
  assign st.data_valid = dv_q;
  assign busy          = state_q == ST_RUN;
  assign done          = state_q == ST_DONE;
  assign wrap          = wrap_q;
  assign wr_err        = werr_q;
endmodule

// File: tb/tb_seq_gen_param.sv
// Bench for seq_gen_param: rule-level stream model plus directed scenarios.
module tb_seq_gen_param;
  logic clk = 0, reset_n = 0;
  always #5 clk = ~clk;

  logic       start = 0, stop = 0, enable = 1, loop_mode = 0, wr_en = 0;
  logic [3:0] len_cfg = 0;
  logic [2:0] wr_addr = 0;
  logic [7:0] wr_data = 0;
  logic       busy, done, wrap, wr_err;

  seq_gen_param_if #(.DATA_W(8)) sif ();
  seq_gen_param #(.DATA_W(8), .DEPTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .enable(enable),
    .loop_mode(loop_mode), .len_cfg(len_cfg), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .st(sif), .busy(busy), .done(done), .wrap(wrap), .wr_err(wr_err)
  );

  // Second instance with a non power-of-two depth for out-of-range writes.
  logic       s_start = 0, s_stop = 0, s_en = 1, s_loop = 0, s_wr_en = 0;
  logic [2:0] s_len = 0, s_wr_addr = 0;
  logic [7:0] s_wr_data = 0;
  logic       s_busy, s_done, s_wrap, s_wr_err;
  seq_gen_param_if #(.DATA_W(8)) sif2 ();
  seq_gen_param #(.DATA_W(8), .DEPTH(5)) dut5 (
    .clk(clk), .reset_n(reset_n), .start(s_start), .stop(s_stop), .enable(s_en),
    .loop_mode(s_loop), .len_cfg(s_len), .wr_en(s_wr_en), .wr_addr(s_wr_addr),
    .wr_data(s_wr_data), .st(sif2), .busy(s_busy), .done(s_done), .wrap(s_wrap),
    .wr_err(s_wr_err)
  );

  int n_chk = 0, n_err = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  logic [7:0] DFLT [8] = '{8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D};
  logic [7:0] PAT2 [3] = '{8'h11, 8'h22, 8'h33};
  logic [7:0] EXP5 [5] = '{8'hAF, 8'hBC, 8'hE2, 8'h78, 8'h44};

  // Model state: table image, running flag, expected next-cycle outputs.
  logic [7:0] mtab [8];
  bit         m_run, m_dv, m_done, m_wrap, m_werr, m_hold, m_loop;
  int         m_len, m_cnt;
  logic [7:0] m_hold_data;
  logic [7:0] got [$];
  logic [7:0] got2 [$];
  int         done_cnt = 0, wrap_cnt = 0, werr_cnt = 0, werr2_cnt = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_dv", sif.data_valid, 0);
      chk("rst_data", sif.data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_wrap", wrap, 0);
      chk("rst_werr", wr_err, 0);
      foreach (mtab[i]) mtab[i] = DFLT[i];
      m_run = 0; m_dv = 0; m_done = 0; m_wrap = 0; m_werr = 0; m_hold = 0;
    end else begin
      bit xfer, idle;
      int pos;
      chk("dv", sif.data_valid, m_dv);
      chk("busy", busy, m_run);
      chk("done", done, m_done);
      chk("wrap", wrap, m_wrap);
      chk("wr_err", wr_err, m_werr);
      if (m_hold) chk("hold", sif.data, m_hold_data);
      if (done) done_cnt++;
      if (wrap) wrap_cnt++;
      if (wr_err) werr_cnt++;
      if (sif.data_valid && sif.data_ready) got.push_back(sif.data);
      xfer = m_dv && sif.data_ready;
      pos = -1;
      if (xfer) begin
        pos = m_cnt % m_len;
        chk("word", sif.data, mtab[pos]);
        m_cnt++;
      end
      idle   = !m_run && !m_done;
      m_werr = wr_en && !idle;
      if (wr_en && idle) mtab[wr_addr] = wr_data;
      m_done = 0; m_wrap = 0; m_hold = 0;
      if (idle) begin
        if (start) begin
          m_run  = 1;
          m_loop = loop_mode;
          m_len  = (len_cfg == 0 || len_cfg > 8) ? 8 : int'(len_cfg);
          m_cnt  = 0;
        end
        m_dv = 0;
      end else if (m_run) begin
        if (stop) begin
          m_run = 0; m_dv = 0;
        end else if (xfer && pos == m_len - 1) begin
          if (m_loop) begin m_wrap = 1; m_dv = enable; end
          else begin m_run = 0; m_done = 1; m_dv = 0; end
        end else if (m_dv && !sif.data_ready) begin
          m_hold = 1; m_hold_data = sif.data;
        end else m_dv = enable;
      end else m_dv = 0;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (s_wr_err) werr2_cnt++;
      if (sif2.data_valid && sif2.data_ready) got2.push_back(sif2.data);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    wr_en = 1; wr_addr = a; wr_data = d; tick(); wr_en = 0;
  endtask

  task automatic go(input logic [3:0] len, input logic lp);
    start = 1; len_cfg = len; loop_mode = lp; tick(); start = 0;
  endtask

  task automatic wait_idle(input string nm, input int bound);
    int k = 0;
    while ((busy || done) && k < bound) begin @(negedge clk); k++; end
    if (busy || done) begin
      n_chk++; n_err++;
      $display("FAIL %s: timeout busy=%0b done=%0b", nm, busy, done);
    end
    tick();
  endtask

  task automatic wait_got(input string nm, input int n, input int bound);
    int k = 0;
    while (got.size() < n && k < bound) begin @(negedge clk); k++; end
    if (got.size() < n) begin
      n_chk++; n_err++;
      $display("FAIL %s: timeout words=%0d want %0d", nm, got.size(), n);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    sif.data_ready = 1; sif2.data_ready = 1;
    tick(3);
    reset_n = 1; tick();

    // One-shot playback of defaults, latency of two cycles.
    got.delete();
    go(8, 0);
    @(negedge clk); chk("lat1_dv", sif.data_valid, 0);
    @(negedge clk); chk("lat2_dv", sif.data_valid, 1); chk("lat2_data", sif.data, 8'hAF);
    wait_idle("t1", 30);
    chk("t1_n", got.size(), 8);
    for (int i = 0; i < 8; i++) if (i < got.size()) chk("t1_w", got[i], DFLT[i]);
    chk("t1_done", done_cnt, 1);
    chk("t1_busy", busy, 0);

    // Loop mode over a reprogrammed 3-entry prefix, then stop.
    wr(0, 8'h11); wr(1, 8'h22); wr(2, 8'h33);
    got.delete(); wrap_cnt = 0;
    go(3, 1);
    wait_got("t2", 7, 40);
    sif.data_ready = 0; tick();
    stop = 1; tick(); stop = 0;
    @(negedge clk); chk("t2_stop_dv", sif.data_valid, 0); chk("t2_busy", busy, 0);
    n = got.size();
    chk("t2_wrap", wrap_cnt, n / 3);
    for (int i = 0; i < n; i++) chk("t2_w", got[i], PAT2[i % 3]);
    chk("t2_nodone", done_cnt, 1);
    sif.data_ready = 1; tick();

    // Backpressure on the second word, plus an ignored start in RUN.
    reset_n = 0; tick(2); reset_n = 1; tick();
    got.delete(); done_cnt = 0;
    go(8, 0);
    tick(2);
    sif.data_ready = 0; start = 1; tick(); start = 0;
    repeat (3) begin
      @(negedge clk); chk("t3_hold_v", sif.data_valid, 1); chk("t3_hold_d", sif.data, 8'hBC);
    end
    @(posedge clk); #1; sif.data_ready = 1;
    wait_got("t3", 3, 10);
    if (got.size() >= 3) begin chk("t3_w1", got[1], 8'hBC); chk("t3_w2", got[2], 8'hE2); end
    wait_idle("t3", 30);
    chk("t3_n", got.size(), 8);
    chk("t3_done", done_cnt, 1);

    // Pause via enable right at the first transfer.
    got.delete();
    go(8, 0);
    tick();
    enable = 0; tick();
    repeat (3) begin @(negedge clk); chk("t4_pause", sif.data_valid, 0); end
    @(posedge clk); #1; enable = 1;
    wait_idle("t4", 30);
    chk("t4_n", got.size(), 8);
    for (int i = 0; i < 8; i++) if (i < got.size()) chk("t4_w", got[i], DFLT[i]);

    // Rejected writes: during RUN, and out of range on the depth-5 instance.
    werr_cnt = 0; got.delete();
    go(8, 0); tick(); wr(3, 8'h55);
    wait_idle("t5", 30);
    chk("t5_werr", werr_cnt, 1);
    if (got.size() > 3) chk("t5_w3", got[3], 8'h78);
    s_wr_en = 1; s_wr_addr = 3'd5; s_wr_data = 8'h66; tick();
    s_wr_addr = 3'd4; s_wr_data = 8'h44; tick(); s_wr_en = 0; tick();
    chk("t5_werr5", werr2_cnt, 1);
    got2.delete();
    s_start = 1; tick(); s_start = 0; tick(12);
    chk("t5_n5", got2.size(), 5);
    for (int i = 0; i < 5; i++) if (i < got2.size()) chk("t5_w5", got2[i], EXP5[i]);

    // Reset mid-sequence restores defaults; start+stop together starts.
    wr(0, 8'h99); got.delete();
    go(8, 0);
    wait_got("t6", 3, 10);
    chk("t6_prog", got[0], 8'h99);
    reset_n = 0;
    @(negedge clk);
    chk("t6_rst_dv", sif.data_valid, 0); chk("t6_rst_data", sif.data, 0);
    chk("t6_rst_busy", busy, 0);
    tick(); reset_n = 1; tick();
    got.delete();
    start = 1; stop = 1; len_cfg = 0; loop_mode = 0; tick(); start = 0; stop = 0;
    wait_idle("t6", 30);
    chk("t6_n", got.size(), 8);
    for (int i = 0; i < 8; i++) if (i < got.size()) chk("t6_w", got[i], DFLT[i]);

    // Length boundaries: single word, and oversize clamps to full table.
    got.delete(); go(1, 0); wait_idle("len1", 20);
    chk("len1_n", got.size(), 1);
    if (got.size() > 0) chk("len1_w", got[0], 8'hAF);
    got.delete(); go(12, 0); wait_idle("len12", 30);
    chk("len12_n", got.size(), 8);

    tick(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/seq_gen_param.md
Name: seq_gen_param

Overview:
Parametrised successor to the fixed 8-bit sequence generator. Replays a programmable table of DATA_W-bit words through a valid/ready output stream, in either one-shot or loop mode. The sequence length is selectable, and the stream can be paused and aborted. The block sits between a control/CSR master (table programming, start/stop) and any streaming consumer.

Parameters:
DATA_W, 8, width of each sequence word.
DEPTH, 8, number of table entries (power of two not required, ≥2).
ADDR_W, $clog2(DEPTH), table index width (derived).
LEN_W, $clog2(DEPTH+1), length field width (derived).

Ports:
clk  in  1  clock, all logic on rising edge.
reset_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse; begins a sequence when idle.
stop  in  1  one-cycle pulse; aborts a running sequence.
enable  in  1  when low, no new word is launched (pause).
loop_mode  in  1  sampled at start: 1 = wrap forever, 0 = one-shot.
len_cfg  in  LEN_W  sequence length, sampled at start.
wr_en  in  1  table write strobe.
wr_addr  in  ADDR_W  table write index.
wr_data  in  DATA_W  table write value.
data  out  DATA_W  current stream word.
data_valid  out  1  data holds a valid word.
data_ready  in  1  consumer accepts the word when high with data_valid.
busy  out  1  high in RUN.
done  out  1  one-cycle pulse when a one-shot sequence completes.
wrap  out  1  one-cycle pulse on each loop-mode wrap to index 0.
wr_err  out  1  one-cycle pulse when a write is rejected.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; idx=0; data=0; data_valid=0; busy=0; done=0; wrap=0; wr_err=0.
  - Table reloads defaults from package: AF,BC,E2,78,FF,E2,0B,8D (zero-extended or truncated to DATA_W; entries beyond 8 =0).
- States: IDLE, RUN, DONE.
- IDLE:
  - wr_en writes table[wr_addr]; wr_addr≥DEPTH is ignored and pulses wr_err.
  - start latches loop_mode and len (len_cfg=0 or >DEPTH clamps to DEPTH); goes to RUN with idx=0.
- Table writes outside IDLE are ignored; wr_err pulses the next cycle.
- start and wr_en in the same IDLE cycle: the write commits, and the sequence sees the new value.
- RUN, launch: when data_valid=0 and enable=1, next cycle data=table[idx] and data_valid=1.
  - Latency start→first valid word is 2 cycles when enable=1.
- RUN, hold: once asserted, data and data_valid stay stable until data_valid&&data_ready; enable does not retract a presented word.
- RUN, transfer (data_valid&&data_ready):
  - If idx<len-1: idx++. If enable=1, the next word is presented in the following cycle (back-to-back, one word per cycle at ready=1). Otherwise data_valid drops.
  - If idx==len-1 and loop: idx=0, wrap pulses, continue.
  - If idx==len-1 and one-shot: data_valid=0, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- stop in RUN: data_valid=0 next cycle regardless of a pending word; go to IDLE; no done. stop outside RUN is ignored.
- start while in RUN or DONE is ignored.
- start and stop together in IDLE: start wins.
- busy=1 exactly in RUN.
- Mid-operation reset: immediate return to reset values, including table defaults.

Decomposition:
- Package seq_gen_pkg:
  - state enum (IDLE, RUN, DONE);
  - default-table constant/function giving the 8-entry default words;
  - length-clamp function.
- Sub-module seq_table: DEPTH×DATA_W register file with async reset to package defaults, one write port, one combinational read port.
- FSM, index counter and output register stay in seq_gen_param.

Test Plan:
1. Reset, start with loop_mode=0, len_cfg=8, ready=1, enable=1 → data AF,BC,E2,78,FF,E2,0B,8D on consecutive cycles from 2 cycles after start; done pulses once; busy=0 afterwards.
2. Program table[0..2]=11,22,33 in IDLE, start with len_cfg=3, loop_mode=1 → stream 11,22,33,11,22,33…; wrap pulses on each return to 11; stop → data_valid=0 next cycle, no done.
3. Backpressure: ready low for 4 cycles while data=BC is valid → data stays BC and data_valid stays 1; after ready rises, E2 follows.
4. enable=0 after the AF transfer → no word presented; enable=1 → BC resumes; no words lost or duplicated.
5. wr_en during RUN, and wr_addr=DEPTH in IDLE → wr_err pulses each time; table contents unchanged.
6. reset_n low mid-sequence after a table write → all outputs 0, table back to AF… defaults; len_cfg=0 start afterwards plays all 8 words.
